multicycle_control_fsm: RTL and testbench

//  Multi-cycle sequencer for the RV32 datapath; replaces the single-cycle main decoder when one shared memory port is used.

---
 rtl/multicycle_control_fsm_pkg.sv | 80 ++++++++
 rtl/multicycle_control_fsm_if.sv | 31 +++
 rtl/multicycle_control_fsm_timeout.sv | 16 +
 rtl/multicycle_control_fsm.sv | 77 +++++++
 tb/tb_multicycle_control_fsm.sv | 122 ++++++++++++
 5 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// riscv_ctrl_pkg: opcodes, control encodings, state type and per-state strobe decode
package riscv_ctrl_pkg;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_SB = 7'b1100011;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  typedef enum logic [3:0] {
    RST, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP
  } state_t;
  typedef struct packed {
    logic mem_req;
    logic iord;
    logic alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic mem_read;
    logic mem_write;
    logic reg_to_mem;
    logic mem_to_reg;
    logic reg_write;
    logic branch;
  } ctrl_t;
  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req = 1'b1;
        c.mem_read = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op = ALUOP_ADD;
      end
      DECODE: c.alu_src_b = SRCB_IMM;
      EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op = ALUOP_FUNCT;
      end
      EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op = ALUOP_FUNCT;
      end
      ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        c.mem_req = 1'b1;
        c.mem_read = 1'b1;
        c.iord = 1'b1;
      end
      MEM_WR: begin
        c.mem_req = 1'b1;
        c.mem_write = 1'b1;
        c.iord = 1'b1;
        c.reg_to_mem = 1'b1;
      end
      WB_ALU: c.reg_write = 1'b1;
      WB_MEM: begin
        c.reg_write = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op = ALUOP_SUB;
        c.branch = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: controller <-> datapath/memory signal bundle
interface multicycle_control_fsm_if #(parameter int RET_W = 32);
  logic [6:0] Opcode;
  logic mem_ready;
  logic mem_req;
  logic IorD;
  logic IRWrite;
  logic PCWrite;
  logic Branch;
  logic ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic MemRead;
  logic MemWrite;
  logic RegtoMem;
  logic MemtoReg;
  logic RegWrite;
  logic illegal;
  logic timeout;
  logic [RET_W-1:0] retired;
  modport master (
    input Opcode, mem_ready,
    output mem_req, IorD, IRWrite, PCWrite, Branch, ALUSrcA, ALUSrcB, ALUOp,
    output MemRead, MemWrite, RegtoMem, MemtoReg, RegWrite, illegal, timeout, retired
  );
  modport slave (
    output Opcode, mem_ready,
    input mem_req, IorD, IRWrite, PCWrite, Branch, ALUSrcA, ALUSrcB, ALUOp,
    input MemRead, MemWrite, RegtoMem, MemtoReg, RegWrite, illegal, timeout, retired
  );
endinterface

// File: rtl/multicycle_control_fsm_timeout.sv
// ctrl_mem_timeout: memory wait counter flagging the last permitted wait cycle
module ctrl_mem_timeout #(parameter int MEM_TIMEOUT = 16) (
  input logic clk,
  input logic rst,
  input logic clr_i,
  input logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(MEM_TIMEOUT);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  end
  assign expired_o = cnt_q == CW'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: RV32 multi-cycle sequencer with memory handshake, timeout trap and retire count
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W = 32
) (
  input logic clk,
  input logic reset,
  multicycle_control_fsm_if.master bus
);
  state_t state_q, state_d;
  ctrl_t ctrl_q;
  logic store_q, illegal_q, timeout_q;
  logic [RET_W-1:0] retired_q;
  logic mem_wait, expired, to_trap, retire;
  assign mem_wait = state_q inside {FETCH, MEM_RD, MEM_WR};
  assign to_trap = mem_wait && !bus.mem_ready && expired;
  assign retire = (state_q inside {WB_ALU, WB_MEM, BRANCH}) || (state_q == MEM_WR && bus.mem_ready);
  always_comb begin
    state_d = state_q;
    case (state_q)
      RST: state_d = FETCH;
      FETCH: state_d = bus.mem_ready ? DECODE : expired ? TRAP : FETCH;
      DECODE: state_d = bus.Opcode == OP_R ? EXEC_R :
                        bus.Opcode == OP_I ? EXEC_I :
                        (bus.Opcode == OP_LOAD || bus.Opcode == OP_S) ? ADDR :
                        bus.Opcode == OP_SB ? BRANCH : TRAP;
      EXEC_R, EXEC_I: state_d = WB_ALU;
      ADDR: state_d = store_q ? MEM_WR : MEM_RD;
      MEM_RD: state_d = bus.mem_ready ? WB_MEM : expired ? TRAP : MEM_RD;
      MEM_WR: state_d = bus.mem_ready ? FETCH : expired ? TRAP : MEM_WR;
      WB_ALU, WB_MEM, BRANCH: state_d = FETCH;
      default: state_d = TRAP;
    endcase
  end
  ctrl_mem_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk(clk),
    .rst(reset),
    .clr_i(state_d != state_q),
    .en_i(mem_wait && !bus.mem_ready),
    .expired_o(expired)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST;
      ctrl_q <= '0;
      store_q <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q <= decode(state_d);
      if (state_q == DECODE) store_q <= bus.Opcode == OP_S;
      illegal_q <= illegal_q | (state_d == TRAP);
      timeout_q <= timeout_q | to_trap;
      retired_q <= retired_q + RET_W'(retire);
    end
  end
  assign bus.mem_req = ctrl_q.mem_req;
  assign bus.IorD = ctrl_q.iord;
  assign bus.IRWrite = state_q == FETCH && bus.mem_ready;
  assign bus.PCWrite = state_q == FETCH && bus.mem_ready;
  assign bus.Branch = ctrl_q.branch;
  assign bus.ALUSrcA = ctrl_q.alu_src_a;
  assign bus.ALUSrcB = ctrl_q.alu_src_b;
  assign bus.ALUOp = ctrl_q.alu_op;
  assign bus.MemRead = ctrl_q.mem_read;
  assign bus.MemWrite = ctrl_q.mem_write;
  assign bus.RegtoMem = ctrl_q.reg_to_mem;
  assign bus.MemtoReg = ctrl_q.mem_to_reg;
  assign bus.RegWrite = ctrl_q.reg_write;
  assign bus.illegal = illegal_q;
  assign bus.timeout = timeout_q;
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed per-cycle check of control strobes, traps and retire count
module tb_multicycle_control_fsm;
  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  multicycle_control_fsm_if #(.RET_W(32)) bus ();
  multicycle_control_fsm #(.MEM_TIMEOUT(16), .RET_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  typedef struct {
    string tag;
    logic [16:0] ctl;
    logic [31:0] ret;
  } exp_t;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  logic exp_ill = 1'b0;
  logic exp_to = 1'b0;
  logic [31:0] exp_ret = '0;
  function automatic logic [16:0] exp_ctl(input string s, input logic rdy, input logic ill, input logic to);
    logic mq, io, br, sa, mr, mw, rm, mtr, rw;
    logic [1:0] sbv, ao;
    {mq, io, br, sa, mr, mw, rm, mtr, rw} = '0;
    sbv = 2'b00;
    ao = 2'b00;
    case (s)
      "FETCH": begin mq = 1; mr = 1; sbv = 2'b01; end
      "DECODE": sbv = 2'b10;
      "EXEC_R": begin sa = 1; ao = 2'b10; end
      "EXEC_I": begin sa = 1; sbv = 2'b10; ao = 2'b10; end
      "ADDR": begin sa = 1; sbv = 2'b10; end
      "MEM_RD": begin mq = 1; mr = 1; io = 1; end
      "MEM_WR": begin mq = 1; mw = 1; io = 1; rm = 1; end
      "WB_ALU": rw = 1;
      "WB_MEM": begin rw = 1; mtr = 1; end
      "BRANCH": begin sa = 1; ao = 2'b01; br = 1; end
      default: ;
    endcase
    return {mq, io, s == "FETCH" && rdy, s == "FETCH" && rdy, br, sa, sbv, ao, mr, mw, rm, mtr, rw, ill, to};
  endfunction
  task automatic step(input string st, input logic rdy, input logic [6:0] op, input logic rst);
    exp_t e, g;
    logic [16:0] obs;
    bus.mem_ready = rdy;
    bus.Opcode = op;
    reset = rst;
    e.tag = st;
    e.ctl = exp_ctl(st, rdy, exp_ill, exp_to);
    e.ret = exp_ret;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    obs = {bus.mem_req, bus.IorD, bus.IRWrite, bus.PCWrite, bus.Branch, bus.ALUSrcA, bus.ALUSrcB,
           bus.ALUOp, bus.MemRead, bus.MemWrite, bus.RegtoMem, bus.MemtoReg, bus.RegWrite,
           bus.illegal, bus.timeout};
    vectors++;
    assert (obs === g.ctl) else begin
      miscompares++;
      $error("FAIL %s ctl observed=%b expected=%b", g.tag, obs, g.ctl);
    end
    vectors++;
    assert (bus.retired === g.ret) else begin
      miscompares++;
      $error("FAIL %s retired observed=%0d expected=%0d", g.tag, bus.retired, g.ret);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      exp_ret = '0;
      exp_ill = 1'b0;
      exp_to = 1'b0;
    end else if (st == "WB_ALU" || st == "WB_MEM" || st == "BRANCH" || (st == "MEM_WR" && rdy)) exp_ret++;
  endtask
  initial begin
    bus.mem_ready = 1'b1;
    bus.Opcode = '0;
    @(posedge clk);
    #1;
    repeat (3) step("RST", 1, R, 1);
    step("RST", 1, R, 0);
    step("FETCH", 1, R, 0); step("DECODE", 1, R, 0); step("EXEC_R", 1, R, 0); step("WB_ALU", 1, R, 0);
    step("FETCH", 1, LD, 0); step("DECODE", 1, LD, 0); step("ADDR", 1, LD, 0);
    repeat (3) step("MEM_RD", 0, LD, 0);
    step("MEM_RD", 1, LD, 0); step("WB_MEM", 1, LD, 0);
    step("FETCH", 1, ST, 0); step("DECODE", 1, ST, 0); step("ADDR", 1, ST, 0); step("MEM_WR", 1, ST, 0);
    step("FETCH", 1, BR, 0); step("DECODE", 1, BR, 0); step("BRANCH", 1, BR, 0);
    step("FETCH", 0, I, 0); step("FETCH", 1, I, 0); step("DECODE", 1, I, 0); step("EXEC_I", 1, I, 0);
    step("WB_ALU", 1, I, 0);
    step("FETCH", 1, ST, 0); step("DECODE", 1, ST, 0); step("ADDR", 1, ST, 0);
    step("MEM_WR", 0, ST, 0); step("MEM_WR", 1, ST, 0);
    step("FETCH", 1, BAD, 0); step("DECODE", 1, BAD, 0);
    exp_ill = 1'b1;
    for (int k = 0; k < 20; k++) step("TRAP", logic'(k % 2), R, 0);
    step("TRAP", 1, R, 1);
    step("RST", 1, R, 0);
    step("FETCH", 1, R, 0); step("DECODE", 1, R, 0); step("EXEC_R", 1, R, 1);
    step("RST", 1, LD, 0);
    step("FETCH", 1, LD, 0); step("DECODE", 1, LD, 0); step("ADDR", 1, LD, 0);
    step("MEM_RD", 0, LD, 1);
    step("RST", 0, R, 0);
    repeat (16) step("FETCH", 0, R, 0);
    exp_ill = 1'b1;
    exp_to = 1'b1;
    step("TRAP", 1, R, 0); step("TRAP", 0, R, 0);
    step("TRAP", 0, R, 1);
    step("RST", 0, R, 0);
    repeat (15) step("FETCH", 0, R, 0);
    step("FETCH", 1, R, 0); step("DECODE", 1, R, 0); step("EXEC_R", 1, R, 0); step("WB_ALU", 1, R, 0);
    step("FETCH", 1, R, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
